// File: rtl/motor_pulse_driver.sv
// Dual-channel motor pulse driver: emits a command's worth of fixed-length
// PWM frames on two outputs, with abort, completion strobe and frame count.
module motor_pulse_driver #(
   parameter int FRAME_CYCLES = 1000000
) (
   input  logic        iClk,
   input  logic        iRST,
   input  logic [20:0] iLeftWidth,
   input  logic [20:0] iRightWidth,
   input  logic [9:0]  iNumPulses,
   input  logic        iStart,
   input  logic        iStop,
   output logic        oLeftPWM,
   output logic        oRightPWM,
   output logic        oBusy,
   output logic        oDone,
   output logic [9:0]  oPulseCount
);

   localparam logic [20:0] FRAME_LEN  = 21'(FRAME_CYCLES);
   localparam logic [20:0] FRAME_LAST = 21'(FRAME_CYCLES - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      r_state, w_state;
   logic [20:0] r_cnt, w_cnt;
   logic [20:0] r_lw, w_lw;
   logic [20:0] r_rw, w_rw;
   logic [9:0]  r_n, w_n;
   logic [9:0]  r_count, w_count;
   logic        r_pwm_l, w_pwm_l;
   logic        r_pwm_r, w_pwm_r;
   logic        r_done, w_done;
   logic [20:0] w_clamp_l, w_clamp_r;
   logic [20:0] w_cnt_inc;

   // State and output registers; reset clears everything asynchronously
   always_ff @(posedge iClk or posedge iRST) begin
      if (iRST) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_lw    <= '0;
         r_rw    <= '0;
         r_n     <= '0;
         r_count <= '0;
         r_pwm_l <= 1'b0;
         r_pwm_r <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_lw    <= w_lw;
         r_rw    <= w_rw;
         r_n     <= w_n;
         r_count <= w_count;
         r_pwm_l <= w_pwm_l;
         r_pwm_r <= w_pwm_r;
         r_done  <= w_done;
      end
   end

   // Next-state logic; PWM outputs are computed from the next counter value
   // so the registered outputs line up with the counter cycle they describe
   always_comb begin
      w_state   = r_state;
      w_cnt     = r_cnt;
      w_lw      = r_lw;
      w_rw      = r_rw;
      w_n       = r_n;
      w_count   = r_count;
      w_pwm_l   = 1'b0;
      w_pwm_r   = 1'b0;
      w_done    = 1'b0;
      w_clamp_l = (iLeftWidth  > FRAME_LEN) ? FRAME_LEN : iLeftWidth;
      w_clamp_r = (iRightWidth > FRAME_LEN) ? FRAME_LEN : iRightWidth;
      w_cnt_inc = r_cnt + 21'd1;

      case (r_state)
         IDLE: begin
            if (iStart && !iStop) begin
               w_count = '0;
               if (iNumPulses == '0) begin
                  w_done = 1'b1;
               end else begin
                  w_state = RUN;
                  w_cnt   = '0;
                  w_lw    = w_clamp_l;
                  w_rw    = w_clamp_r;
                  w_n     = iNumPulses;
                  w_pwm_l = (w_clamp_l != '0);
                  w_pwm_r = (w_clamp_r != '0);
               end
            end
         end
         RUN: begin
            if (iStop) begin
               w_state = IDLE;
               w_cnt   = '0;
            end else if (r_cnt == FRAME_LAST) begin
               w_count = r_count + 10'd1;
               w_cnt   = '0;
               if (r_count + 10'd1 == r_n) begin
                  w_state = IDLE;
                  w_done  = 1'b1;
               end else begin
                  w_pwm_l = (r_lw != '0);
                  w_pwm_r = (r_rw != '0);
               end
            end else begin
               w_cnt   = w_cnt_inc;
               w_pwm_l = (w_cnt_inc < r_lw);
               w_pwm_r = (w_cnt_inc < r_rw);
            end
         end
         default: begin
            w_state = IDLE;
         end
      endcase
   end

   assign oLeftPWM    = r_pwm_l;
   assign oRightPWM   = r_pwm_r;
   assign oBusy       = (r_state == RUN);
   assign oDone       = r_done;
   assign oPulseCount = r_count;

endmodule

// File: tb/tb_motor_pulse_driver.sv
// Directed self-checking bench for motor_pulse_driver with 100-cycle frames.
module tb_motor_pulse_driver;

   localparam int FC = 100;

   logic        iClk = 1'b0;
   logic        iRST = 1'b1;
   logic [20:0] iLeftWidth = '0;
   logic [20:0] iRightWidth = '0;
   logic [9:0]  iNumPulses = '0;
   logic        iStart = 1'b0;
   logic        iStop = 1'b0;
   logic        oLeftPWM, oRightPWM, oBusy, oDone;
   logic [9:0]  oPulseCount;

   int checks = 0;
   int failures = 0;

   motor_pulse_driver #(.FRAME_CYCLES(FC)) dut (
      .iClk(iClk), .iRST(iRST), .iLeftWidth(iLeftWidth), .iRightWidth(iRightWidth),
      .iNumPulses(iNumPulses), .iStart(iStart), .iStop(iStop),
      .oLeftPWM(oLeftPWM), .oRightPWM(oRightPWM), .oBusy(oBusy),
      .oDone(oDone), .oPulseCount(oPulseCount)
   );

   always #5 iClk = ~iClk;

   task automatic step();
      @(negedge iClk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag, input logic [31:0] done_exp, input logic [31:0] cnt_exp);
      chk({tag, "_busy"}, {31'd0, oBusy}, 0);
      chk({tag, "_pwm"}, {30'd0, oLeftPWM, oRightPWM}, 0);
      chk({tag, "_done"}, {31'd0, oDone}, done_exp);
      chk({tag, "_count"}, {22'd0, oPulseCount}, cnt_exp);
   endtask

   // Observe cycles k0..k1-1 of a running command against the frame model
   task automatic run(input string tag, input int k0, input int k1,
                      input int lw, input int rw, input int cbase);
      int err;
      int lc, rc;
      logic el, er;
      err = 0;
      lc = (lw > FC) ? FC : lw;
      rc = (rw > FC) ? FC : rw;
      for (int k = k0; k < k1; k++) begin
         el = ((k % FC) < lc);
         er = ((k % FC) < rc);
         if (oLeftPWM !== el || oRightPWM !== er || oBusy !== 1'b1 || oDone !== 1'b0 ||
             oPulseCount !== 10'(cbase + k / FC))
            err++;
         step();
      end
      chk(tag, err, 0);
   endtask

   task automatic start_cmd(input int lw, input int rw, input int n);
      iLeftWidth  = 21'(lw);
      iRightWidth = 21'(rw);
      iNumPulses  = 10'(n);
      iStart      = 1'b1;
      step();
      iStart      = 1'b0;
   endtask

   initial begin
      // reset state
      step();
      step();
      chk_idle("reset", 0, 0);
      iRST = 1'b0;
      step();

      // three frames, L=30 R=50
      start_cmd(30, 50, 3);
      run("t1_frames", 0, 300, 30, 50, 0);
      chk_idle("t1_end", 1, 3);
      step();
      chk_idle("t1_after", 0, 3);

      // zero pulse count: immediate done, no activity
      iNumPulses = '0;
      iLeftWidth = 21'd40;
      iStart = 1'b1;
      step();
      iStart = 1'b0;
      chk_idle("t2_done", 1, 0);
      step();
      chk_idle("t2_after", 0, 0);

      // zero and over-range widths
      start_cmd(0, 150, 2);
      run("t3_frames", 0, 200, 0, 150, 0);
      chk_idle("t3_end", 1, 2);
      step();

      // stop mid-command; start strobe and input changes during run ignored
      start_cmd(30, 60, 5);
      run("t4_a", 0, 20, 30, 60, 0);
      iLeftWidth = 21'd80;
      iNumPulses = 10'd1;
      iStart = 1'b1;
      run("t4_b", 20, 21, 30, 60, 0);
      iStart = 1'b0;
      run("t4_c", 21, 250, 30, 60, 0);
      iStop = 1'b1;
      step();
      iStop = 1'b0;
      chk_idle("t4_stop", 0, 2);
      step();
      chk_idle("t4_after", 0, 2);

      // stop and start together in idle: stop wins
      iLeftWidth = 21'd30;
      iNumPulses = 10'd1;
      iStart = 1'b1;
      iStop = 1'b1;
      step();
      iStart = 1'b0;
      iStop = 1'b0;
      chk_idle("t5_both", 0, 2);

      // asynchronous reset mid-frame, then a clean command
      start_cmd(30, 0, 3);
      run("t6_pre", 0, 40, 30, 0, 0);
      #1 iRST = 1'b1;
      #1;
      chk_idle("t6_rst", 0, 0);
      step();
      iRST = 1'b0;
      step();
      chk_idle("t6_post", 0, 0);
      start_cmd(10, 0, 1);
      run("t6_frame", 0, 100, 10, 0, 0);
      chk_idle("t6_end", 1, 1);

      // back-to-back command accepted in the done cycle
      step();
      start_cmd(50, 0, 1);
      run("t7_first", 0, 100, 50, 0, 0);
      chk({"t7_done"}, {31'd0, oDone}, 1);
      start_cmd(20, 0, 1);
      run("t7_second", 0, 100, 20, 0, 0);
      chk_idle("t7_end", 1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/motor_pulse_driver.md
MOTOR_PULSE_DRIVER -- requirements
Module: motor_pulse_driver

Interface
REQ-001 SHALL have parameter FRAME_CYCLES, default 1000000, meaning PWM frame length in iClk cycles (20 ms at 50 MHz); legal range 2..2097151.
REQ-002 SHALL have port iClk, input, 1, system clock; all logic on rising edge.
REQ-003 SHALL have port iRST, input, 1, reset, asynchronous, active-high.
REQ-004 SHALL have port iLeftWidth, input, 21, left motor high time per frame in cycles.
REQ-005 SHALL have port iRightWidth, input, 21, right motor high time per frame in cycles.
REQ-006 SHALL have port iNumPulses, input, 10, number of frames to emit per command.
REQ-007 SHALL have port iStart, input, 1, command strobe; sampled every edge.
REQ-008 SHALL have port iStop, input, 1, abort request; sampled every edge.
REQ-009 SHALL have port oLeftPWM, input-derived output, 1, registered left motor pulse.
REQ-010 SHALL have port oRightPWM, output, 1, registered right motor pulse.
REQ-011 SHALL have port oBusy, output, 1, high while in RUN.
REQ-012 SHALL have port oDone, output, 1, one-cycle pulse on normal completion.
REQ-013 SHALL have port oPulseCount, output, 10, number of frames completed in current/last command.

Function
REQ-014 SHALL implement two states, IDLE and RUN; all outputs registered.
REQ-015 In IDLE, iStart=1 and iStop=0 at an edge SHALL latch iLeftWidth, iRightWidth, iNumPulses, clear frame counter and oPulseCount to 0, and enter RUN at that same edge.
REQ-016 In IDLE with iStart=1 and iNumPulses=0, SHALL stay IDLE, pulse oDone for one cycle, oPulseCount=0, no PWM activity.
REQ-017 Latched widths greater than FRAME_CYCLES SHALL be clamped to FRAME_CYCLES (output high for the whole frame).
REQ-018 In RUN, a 21-bit frame counter SHALL count 0..FRAME_CYCLES-1 and wrap to 0; the cycle immediately after the accepting edge is counter value 0.
REQ-019 oLeftPWM SHALL be high in every cycle where counter < latched left width, else low; identically for oRightPWM; width 0 keeps the output low for the whole command.
REQ-020 On each wrap (counter = FRAME_CYCLES-1), oPulseCount SHALL increment by 1 at that edge.
REQ-021 When the increment makes oPulseCount equal the latched count, the same edge SHALL enter IDLE, drive oBusy=0 and both PWM low, and set oDone=1 for exactly one cycle.
REQ-022 iStart during RUN SHALL be ignored; input changes during RUN SHALL not affect the active command.
REQ-023 iStop=1 at any edge in RUN SHALL enter IDLE at that edge with PWM low and oBusy=0; oDone SHALL not pulse; oPulseCount holds frames completed so far.
REQ-024 iStop and iStart both high in IDLE: iStop SHALL win, no command accepted.
REQ-025 A new command SHALL be acceptable at the edge during which oDone is high (back-to-back, no gap cycle required).
REQ-026 oBusy SHALL equal (state == RUN).

Reset
REQ-027 iRST=1 SHALL, asynchronously and at any time including mid-frame, force IDLE, oLeftPWM=0, oRightPWM=0, oBusy=0, oDone=0, oPulseCount=0, frame counter=0, latched widths and count=0.
REQ-028 After iRST deasserts, first iStart SHALL be accepted at the first edge where it is sampled high.

Verification (FRAME_CYCLES=100)
REQ-029 iStart with L=30, R=50, N=3 -> oLeftPWM high 30 cycles then low 70, oRightPWM high 50 / low 50, per frame, 3 frames; oDone one cycle at cycle 300; oPulseCount=3.
REQ-030 iStart with N=0 -> oDone pulse next cycle, oBusy never high, PWM never high.
REQ-031 L=0, R=150, N=2 -> oLeftPWM always low; oRightPWM high for all 200 cycles; oDone after 200 cycles.
REQ-032 L=30, N=5, iStop at cycle 250 -> PWM low and oBusy=0 next cycle, no oDone, oPulseCount=2; iStart pulses during run have no effect.
REQ-033 iRST asserted at cycle 40 of frame 1 -> all outputs 0 immediately; following iStart L=10, N=1 -> clean 10-cycle pulse and oDone at cycle 100.
REQ-034 iStart re-asserted in the oDone cycle with new L=20, N=1 -> second command starts with no idle gap, 20-cycle high pulse.
